// File: rtl/rib_pkg.sv
// Shared widths, FSM state encoding and error-response constants for the RIB bus.
package rib_pkg;

    localparam int RIB_ADDR_W   = 32;
    localparam int RIB_DATA_W   = 32;
    localparam int RIB_SEL_W    = 4;
    localparam int RIB_DEC_BITS = 4;

    localparam logic [RIB_DATA_W-1:0] RIB_ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } rib_state_t;

endpackage

// File: rtl/rib_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above i_ptr, wrapping modulo N.
module rib_rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx
);

    logic         w_found;
    logic [W:0]   w_j;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_j = {1'b0, i_ptr} + (W+1)'(k);
            if (w_j >= (W+1)'(N)) begin
                w_j = w_j - (W+1)'(N);
            end
            if (!w_found && i_req[w_j[W-1:0]]) begin
                w_found            = 1'b1;
                o_gnt[w_j[W-1:0]]  = 1'b1;
                o_idx              = w_j[W-1:0];
            end
        end
    end

endmodule

// File: rtl/rib_rr_bus.sv
// Shared-path RIB interconnect: round-robin master grant, registered slave select, decode-error responder.
// Optional watchdog and ERR state are compiled in with `define RIB_TIMEOUT_EN.
module rib_rr_bus
    import rib_pkg::*;
#(
    parameter int MASTER_NUM     = 4,
    parameter int SLAVE_NUM      = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [RIB_ADDR_W*MASTER_NUM-1:0] m_addr_i,
    input  logic [RIB_DATA_W*MASTER_NUM-1:0] m_data_i,
    input  logic [RIB_SEL_W*MASTER_NUM-1:0]  m_sel_i,
    input  logic [MASTER_NUM-1:0]            m_we_i,
    input  logic [MASTER_NUM-1:0]            m_req_vld_i,
    input  logic [MASTER_NUM-1:0]            m_rsp_rdy_i,
    output logic [MASTER_NUM-1:0]            m_req_rdy_o,
    output logic [MASTER_NUM-1:0]            m_rsp_vld_o,
    output logic [RIB_DATA_W*MASTER_NUM-1:0] m_data_o,
    output logic [MASTER_NUM-1:0]            m_err_o,
    output logic [RIB_ADDR_W*SLAVE_NUM-1:0]  s_addr_o,
    output logic [RIB_DATA_W*SLAVE_NUM-1:0]  s_data_o,
    output logic [RIB_SEL_W*SLAVE_NUM-1:0]   s_sel_o,
    output logic [SLAVE_NUM-1:0]             s_we_o,
    output logic [SLAVE_NUM-1:0]             s_req_vld_o,
    output logic [SLAVE_NUM-1:0]             s_rsp_rdy_o,
    input  logic [RIB_DATA_W*SLAVE_NUM-1:0]  s_data_i,
    input  logic [SLAVE_NUM-1:0]             s_req_rdy_i,
    input  logic [SLAVE_NUM-1:0]             s_rsp_vld_i
);

    localparam int IDX_W  = $clog2(MASTER_NUM);
    localparam int OFFS_W = RIB_ADDR_W - RIB_DEC_BITS;

    rib_state_t              r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_gnt_idx;
    logic [MASTER_NUM-1:0]   r_gnt_oh;
    logic [SLAVE_NUM-1:0]    r_slv_oh;
    logic                    r_unmapped;

    logic [MASTER_NUM-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]        w_arb_idx;
    logic [RIB_DEC_BITS-1:0] w_arb_dec;
    logic                    w_arb_unmapped;
    logic [SLAVE_NUM-1:0]    w_arb_slv_oh;

    logic [OFFS_W-1:0]       w_gnt_offs;
    logic [RIB_DATA_W-1:0]   w_gnt_data;
    logic [RIB_SEL_W-1:0]    w_gnt_sel;
    logic                    w_gnt_we;
    logic                    w_gnt_req_vld;
    logic                    w_gnt_rsp_rdy;
    logic                    w_slv_req_rdy;
    logic                    w_slv_rsp_vld;
    logic [RIB_DATA_W-1:0]   w_slv_rdata;

    logic                    w_req_rdy_core;
    logic                    w_req_rdy;
    logic                    w_rsp_vld_core;
    logic                    w_req_hs;
    logic                    w_rsp_hs;
    logic [IDX_W-1:0]        w_ptr_next;

    rib_rr_arbiter #(.N(MASTER_NUM)) u_arb (
        .i_req (m_req_vld_i),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    // One-hot AND-OR selection keeps unselected ports (even X) out of the datapath.
    always_comb begin
        w_gnt_offs = '0;
        w_gnt_data = '0;
        w_gnt_sel  = '0;
        w_arb_dec  = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            w_gnt_offs |= m_addr_i[RIB_ADDR_W*i +: OFFS_W] & {OFFS_W{r_gnt_oh[i]}};
            w_gnt_data |= m_data_i[RIB_DATA_W*i +: RIB_DATA_W] & {RIB_DATA_W{r_gnt_oh[i]}};
            w_gnt_sel  |= m_sel_i[RIB_SEL_W*i +: RIB_SEL_W] & {RIB_SEL_W{r_gnt_oh[i]}};
            w_arb_dec  |= m_addr_i[RIB_ADDR_W*i+OFFS_W +: RIB_DEC_BITS] & {RIB_DEC_BITS{w_arb_gnt[i]}};
        end
    end

    always_comb begin
        w_slv_rdata = '0;
        for (int s = 0; s < SLAVE_NUM; s++) begin
            w_slv_rdata |= s_data_i[RIB_DATA_W*s +: RIB_DATA_W] & {RIB_DATA_W{r_slv_oh[s]}};
        end
    end

    assign w_gnt_we      = |(m_we_i & r_gnt_oh);
    assign w_gnt_req_vld = |(m_req_vld_i & r_gnt_oh);
    assign w_gnt_rsp_rdy = |(m_rsp_rdy_i & r_gnt_oh);
    assign w_slv_req_rdy = |(s_req_rdy_i & r_slv_oh);
    assign w_slv_rsp_vld = |(s_rsp_vld_i & r_slv_oh);

    assign w_arb_unmapped = ({{(32-RIB_DEC_BITS){1'b0}}, w_arb_dec} >= 32'(SLAVE_NUM));

    always_comb begin
        w_arb_slv_oh = '0;
        if (!w_arb_unmapped) begin
            w_arb_slv_oh[w_arb_dec] = 1'b1;
        end
    end

    // The decode-error responder stands in for the slave on both handshakes.
    assign w_req_rdy_core = r_unmapped | w_slv_req_rdy;
    assign w_rsp_vld_core = r_unmapped | w_slv_rsp_vld;
    assign w_req_hs       = w_gnt_req_vld & w_req_rdy_core;
    assign w_rsp_hs       = w_rsp_vld_core & w_gnt_rsp_rdy;
    assign w_ptr_next     = (r_gnt_idx == IDX_W'(MASTER_NUM - 1)) ? '0 : r_gnt_idx + 1'b1;

`ifdef RIB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        w_to;

    assign w_to      = (r_cnt >= 16'(TIMEOUT_CYCLES - 1));
    assign w_req_rdy = w_req_rdy_core | w_to;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_req_rdy        = w_req_rdy_core;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_gnt_idx  <= '0;
            r_gnt_oh   <= '0;
            r_slv_oh   <= '0;
            r_unmapped <= 1'b0;
`ifdef RIB_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|m_req_vld_i) begin
                        r_gnt_idx  <= w_arb_idx;
                        r_gnt_oh   <= w_arb_gnt;
                        r_slv_oh   <= w_arb_slv_oh;
                        r_unmapped <= w_arb_unmapped;
                        r_state    <= REQ;
`ifdef RIB_TIMEOUT_EN
                        r_cnt      <= '0;
`endif
                    end
                end
                REQ: begin
                    if (w_req_hs) begin
                        r_state <= RSP;
`ifdef RIB_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (w_to) begin
                        r_state <= ERR;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
`endif
                    end
                end
                RSP: begin
                    if (w_rsp_hs) begin
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= IDLE;
`ifdef RIB_TIMEOUT_EN
                    end else if (w_to) begin
                        r_state  <= ERR;
                    end else begin
                        r_cnt    <= r_cnt + 16'd1;
`endif
                    end
                end
`ifdef RIB_TIMEOUT_EN
                ERR: begin
                    if (w_gnt_rsp_rdy) begin
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_req_rdy_o = '0;
        m_rsp_vld_o = '0;
        m_data_o    = '0;
        m_err_o     = '0;
        s_addr_o    = '0;
        s_data_o    = '0;
        s_sel_o     = '0;
        s_we_o      = '0;
        s_req_vld_o = '0;
        s_rsp_rdy_o = '0;
        case (r_state)
            REQ: begin
                m_req_rdy_o = r_gnt_oh & {MASTER_NUM{w_req_rdy}};
                for (int s = 0; s < SLAVE_NUM; s++) begin
                    if (r_slv_oh[s]) begin
                        s_addr_o[RIB_ADDR_W*s +: RIB_ADDR_W] = {{RIB_DEC_BITS{1'b0}}, w_gnt_offs};
                        s_data_o[RIB_DATA_W*s +: RIB_DATA_W] = w_gnt_data;
                        s_sel_o[RIB_SEL_W*s +: RIB_SEL_W]    = w_gnt_sel;
                        s_we_o[s]                            = w_gnt_we;
                        s_req_vld_o[s]                       = w_gnt_req_vld;
                    end
                end
            end
            RSP: begin
                m_rsp_vld_o = r_gnt_oh & {MASTER_NUM{w_rsp_vld_core}};
                m_err_o     = r_gnt_oh & {MASTER_NUM{r_unmapped}};
                s_rsp_rdy_o = r_slv_oh & {SLAVE_NUM{w_gnt_rsp_rdy}};
                for (int i = 0; i < MASTER_NUM; i++) begin
                    m_data_o[RIB_DATA_W*i +: RIB_DATA_W] =
                        (r_unmapped ? RIB_ERR_DATA : w_slv_rdata) & {RIB_DATA_W{r_gnt_oh[i]}};
                end
            end
`ifdef RIB_TIMEOUT_EN
            ERR: begin
                m_rsp_vld_o = r_gnt_oh;
                m_err_o     = r_gnt_oh;
                for (int i = 0; i < MASTER_NUM; i++) begin
                    m_data_o[RIB_DATA_W*i +: RIB_DATA_W] = RIB_ERR_DATA & {RIB_DATA_W{r_gnt_oh[i]}};
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rib_rr_bus.sv
// Directed bench for rib_rr_bus (4 masters, 5 slaves); timeout scenario runs when RIB_TIMEOUT_EN is defined.
module tb_rib_rr_bus;

    localparam int M = 4;
    localparam int S = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [32*M-1:0]   m_addr_i;
    logic [32*M-1:0]   m_data_i;
    logic [4*M-1:0]    m_sel_i;
    logic [M-1:0]      m_we_i;
    logic [M-1:0]      m_req_vld_i;
    logic [M-1:0]      m_rsp_rdy_i;
    logic [M-1:0]      m_req_rdy_o;
    logic [M-1:0]      m_rsp_vld_o;
    logic [32*M-1:0]   m_data_o;
    logic [M-1:0]      m_err_o;
    logic [32*S-1:0]   s_addr_o;
    logic [32*S-1:0]   s_data_o;
    logic [4*S-1:0]    s_sel_o;
    logic [S-1:0]      s_we_o;
    logic [S-1:0]      s_req_vld_o;
    logic [S-1:0]      s_rsp_rdy_o;
    logic [32*S-1:0]   s_data_i;
    logic [S-1:0]      s_req_rdy_i;
    logic [S-1:0]      s_rsp_vld_i;

    int n_checks = 0;
    int n_errors = 0;

    rib_rr_bus #(.MASTER_NUM(M), .SLAVE_NUM(S), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_addr_i    (m_addr_i),
        .m_data_i    (m_data_i),
        .m_sel_i     (m_sel_i),
        .m_we_i      (m_we_i),
        .m_req_vld_i (m_req_vld_i),
        .m_rsp_rdy_i (m_rsp_rdy_i),
        .m_req_rdy_o (m_req_rdy_o),
        .m_rsp_vld_o (m_rsp_vld_o),
        .m_data_o    (m_data_o),
        .m_err_o     (m_err_o),
        .s_addr_o    (s_addr_o),
        .s_data_o    (s_data_o),
        .s_sel_o     (s_sel_o),
        .s_we_o      (s_we_o),
        .s_req_vld_o (s_req_vld_o),
        .s_rsp_rdy_o (s_rsp_rdy_o),
        .s_data_i    (s_data_i),
        .s_req_rdy_i (s_req_rdy_i),
        .s_rsp_vld_i (s_rsp_vld_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] one(input int k);
        return 160'(1) << k;
    endfunction

    function automatic logic [159:0] slot32(input int k, input logic [31:0] v);
        return {128'd0, v} << (32 * k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic vld);
        m_addr_i[32*i +: 32] = a;
        m_data_i[32*i +: 32] = d;
        m_we_i[i]            = we;
        m_req_vld_i[i]       = vld;
    endtask

    // Called in IDLE with requests already raised; slave answers in the first RSP cycle.
    task automatic run_txn(input int exp_m, input string tag);
        logic [31:0] a;
        logic [31:0] rd;
        int          slv;
        a   = m_addr_i[32*exp_m +: 32];
        slv = int'(a[31:28]);
        rd  = 32'hD00D_0000 | 32'(exp_m);
        check({tag, "_idle_req_rdy"}, m_req_rdy_o, 0);
        check({tag, "_idle_s_req_vld"}, s_req_vld_o, 0);
        tick();
        check({tag, "_req_rdy"}, m_req_rdy_o, one(exp_m));
        check({tag, "_s_req_vld"}, s_req_vld_o, one(slv));
        check({tag, "_s_addr"}, s_addr_o, slot32(slv, {4'h0, a[27:0]}));
        tick();
        s_rsp_vld_i[slv]         = 1'b1;
        s_data_i[32*slv +: 32]   = rd;
        #1;
        check({tag, "_rsp_vld"}, m_rsp_vld_o, one(exp_m));
        check({tag, "_rsp_data"}, m_data_o, slot32(exp_m, rd));
        tick();
        s_rsp_vld_i = '0;
        s_data_i    = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        m_addr_i    = '0;
        m_data_i    = '0;
        m_sel_i     = '1;
        m_we_i      = '0;
        m_req_vld_i = '0;
        m_rsp_rdy_i = '1;
        s_data_i    = '0;
        s_req_rdy_i = '1;
        s_rsp_vld_i = '0;
        tick();
        check("rst_m_req_rdy", m_req_rdy_o, 0);
        check("rst_m_rsp_vld", m_rsp_vld_o, 0);
        check("rst_s_req_vld", s_req_vld_o, 0);
        check("rst_s_addr", s_addr_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // m1 reads slave 2, response two cycles into RSP
        set_m(1, 32'h2000_0010, 32'h0, 1'b0, 1'b1);
        #1;
        check("t1_idle_req_rdy", m_req_rdy_o, 0);
        tick();
        check("t1_s_req_vld", s_req_vld_o, 5'b00100);
        check("t1_s_addr", s_addr_o, slot32(2, 32'h0000_0010));
        check("t1_req_rdy", m_req_rdy_o, 4'b0010);
        tick();
        m_req_vld_i[1] = 1'b0;
        #1;
        check("t1_rsp_wait", m_rsp_vld_o, 0);
        check("t1_s_rsp_rdy", s_rsp_rdy_o, 5'b00100);
        tick();
        s_rsp_vld_i[2]      = 1'b1;
        s_data_i[64 +: 32]  = 32'hCAFE_F00D;
        #1;
        check("t1_rsp_vld", m_rsp_vld_o, 4'b0010);
        check("t1_rsp_data", m_data_o, slot32(1, 32'hCAFE_F00D));
        check("t1_rsp_err", m_err_o, 0);
        tick();
        s_rsp_vld_i = '0;
        s_data_i    = '0;
        check("t1_after_rsp_vld", m_rsp_vld_o, 0);

        // pointer is now 2: m1 and m2 requesting must grant m2 first, then m1
        set_m(1, 32'h1000_0100, 32'h0, 1'b0, 1'b1);
        set_m(2, 32'h3000_0020, 32'h0, 1'b0, 1'b1);
        run_txn(2, "ptr_m2");
        m_req_vld_i[2] = 1'b0;
        run_txn(1, "ptr_m1");
        m_req_vld_i = '0;

        // reset during RSP with m3 granted
        set_m(3, 32'h3000_004C, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        s_rsp_vld_i[3]      = 1'b1;
        s_data_i[96 +: 32]  = 32'h0000_BEEF;
        #1;
        check("rst_pre_rsp_vld", m_rsp_vld_o, 4'b1000);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_vld", m_rsp_vld_o, 0);
        check("rst_mid_data", m_data_o, 0);
        check("rst_mid_s_rsp_rdy", s_rsp_rdy_o, 0);
        s_rsp_vld_i = '0;
        s_data_i    = '0;
        set_m(0, 32'h0000_0040, 32'h0, 1'b0, 1'b1);
        set_m(1, 32'h1000_0044, 32'h0, 1'b0, 1'b1);
        set_m(2, 32'h2000_0048, 32'h0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        #1;

        // all four requesting continuously from rr_ptr=0
        run_txn(0, "rr_m0a");
        run_txn(1, "rr_m1");
        run_txn(2, "rr_m2");
        run_txn(3, "rr_m3");
        run_txn(0, "rr_m0b");
        m_req_vld_i = '0;

        // m2 writes an unmapped region; stray slave responses in IDLE are ignored
        s_rsp_vld_i = '1;
        set_m(2, 32'h9000_0000, 32'h0000_1234, 1'b1, 1'b1);
        #1;
        check("t3_idle_stray_rsp", m_rsp_vld_o, 0);
        s_rsp_vld_i = '0;
        tick();
        check("t3_s_req_vld", s_req_vld_o, 0);
        check("t3_s_addr", s_addr_o, 0);
        check("t3_s_we", s_we_o, 0);
        check("t3_req_rdy", m_req_rdy_o, 4'b0100);
        tick();
        m_req_vld_i[2] = 1'b0;
        #1;
        check("t3_rsp_vld", m_rsp_vld_o, 4'b0100);
        check("t3_rsp_err", m_err_o, 4'b0100);
        check("t3_rsp_data", m_data_o, 0);
        tick();
        check("t3_idle_rsp_vld", m_rsp_vld_o, 0);
        check("t3_idle_err", m_err_o, 0);

        // slave 0 stalls request 5 cycles, m0 stalls response 3 cycles
        s_req_rdy_i[0] = 1'b0;
        m_sel_i[3:0]   = 4'b0011;
        set_m(0, 32'h0000_0ABC, 32'h0000_55AA, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_stall%0d_s_req_vld", k), s_req_vld_o, 5'b00001);
            check($sformatf("t4_stall%0d_s_addr", k), s_addr_o, slot32(0, 32'h0000_0ABC));
            check($sformatf("t4_stall%0d_req_rdy", k), m_req_rdy_o, 0);
            tick();
        end
        s_req_rdy_i[0] = 1'b1;
        #1;
        check("t4_req_rdy", m_req_rdy_o, 4'b0001);
        check("t4_s_data", s_data_o, slot32(0, 32'h0000_55AA));
        check("t4_s_sel", s_sel_o, 20'h00003);
        check("t4_s_we", s_we_o, 5'b00001);
        tick();
        m_req_vld_i[0]     = 1'b0;
        m_rsp_rdy_i[0]     = 1'b0;
        s_rsp_vld_i[0]     = 1'b1;
        s_data_i[0 +: 32]  = 32'h7777_0000;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4_hold%0d_rsp_vld", k), m_rsp_vld_o, 4'b0001);
            check($sformatf("t4_hold%0d_s_rsp_rdy", k), s_rsp_rdy_o, 0);
            tick();
        end
        m_rsp_rdy_i[0] = 1'b1;
        #1;
        check("t4_s_rsp_rdy", s_rsp_rdy_o, 5'b00001);
        check("t4_rsp_data", m_data_o, slot32(0, 32'h7777_0000));
        tick();
        check("t4_no_dup_a", m_rsp_vld_o, 0);
        tick();
        check("t4_no_dup_b", m_rsp_vld_o, 0);
        s_rsp_vld_i  = '0;
        s_data_i     = '0;
        m_sel_i      = '1;
        m_we_i       = '0;

`ifdef RIB_TIMEOUT_EN
        // slave 1 never answers: ERR after 8 RSP cycles
        set_m(1, 32'h1000_0000, 32'h0, 1'b0, 1'b1);
        tick();
        check("t6_req_rdy", m_req_rdy_o, 4'b0010);
        tick();
        m_req_vld_i[1] = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t6_wait%0d_rsp_vld", k), m_rsp_vld_o, 0);
            check($sformatf("t6_wait%0d_s_rsp_rdy", k), s_rsp_rdy_o, 5'b00010);
            tick();
        end
        s_rsp_vld_i[1] = 1'b1;
        #1;
        check("t6_err_rsp_vld", m_rsp_vld_o, 4'b0010);
        check("t6_err_err", m_err_o, 4'b0010);
        check("t6_err_data", m_data_o, 0);
        check("t6_err_s_rsp_rdy", s_rsp_rdy_o, 0);
        tick();
        check("t6_idle_rsp_vld", m_rsp_vld_o, 0);
        s_rsp_vld_i = '0;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rib_rr_bus.md
Name: rib_rr_bus

Overview:
Next-generation RIB system-bus interconnect. It connects MASTER_NUM masters to SLAVE_NUM slaves over one shared path and allows one transaction at a time.
- Fair round-robin arbitration; grant held from request acceptance until the response handshake.
- Registered routing, so masters and slaves see stable selects for the whole transaction.
- Built-in decode-error responder for unmapped regions.
- Sits between core/DMA/debug masters and the memory and peripheral slaves.

Parameters:
MASTER_NUM, 4, number of masters (2..16)
SLAVE_NUM, 5, number of mapped slaves (1..16); slave k owns addr[31:28]==k
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with RIB_TIMEOUT_EN)

Ports:
clk  in  1  bus clock
rst_n  in  1  asynchronous active-low reset
m_addr_i  in  32*MASTER_NUM  per-master address, master i at [32i+31:32i]
m_data_i  in  32*MASTER_NUM  per-master write data
m_sel_i  in  4*MASTER_NUM  per-master byte enables
m_we_i  in  MASTER_NUM  write enable
m_req_vld_i  in  MASTER_NUM  request valid
m_rsp_rdy_i  in  MASTER_NUM  master ready for response
m_req_rdy_o  out  MASTER_NUM  request accepted
m_rsp_vld_o  out  MASTER_NUM  response valid
m_data_o  out  32*MASTER_NUM  read data
m_err_o  out  MASTER_NUM  error response qualifier (valid with rsp_vld)
s_addr_o  out  32*SLAVE_NUM  offset address {4'h0, addr[27:0]}
s_data_o  out  32*SLAVE_NUM  write data
s_sel_o  out  4*SLAVE_NUM  byte enables
s_we_o  out  SLAVE_NUM  write enable
s_req_vld_o  out  SLAVE_NUM  request valid
s_rsp_rdy_o  out  SLAVE_NUM  ready for response
s_data_i  in  32*SLAVE_NUM  read data
s_req_rdy_i  in  SLAVE_NUM  slave accepts request
s_rsp_vld_i  in  SLAVE_NUM  slave response valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, grant=0, slave index=0. All outputs 0. Reset mid-transaction abandons it silently; no response is issued.
- State machine IDLE -> REQ -> RSP -> IDLE (plus ERR when RIB_TIMEOUT_EN is defined).
- IDLE:
  - If any m_req_vld_i is set, pick the first requester searching from rr_ptr upward, wrapping modulo MASTER_NUM.
  - Register gnt_idx, the decoded slave index (addr[31:28]) and an unmapped flag (index >= SLAVE_NUM). Go to REQ.
  - Arbitration latency: 1 cycle. No outputs are asserted in IDLE.
- REQ:
  - Drive the granted master's addr (offset), data, sel, we and req_vld to the registered slave only. All other slave outputs are 0.
  - m_req_rdy_o[gnt] = s_req_rdy_i[slv]. Same-cycle handshake moves to RSP.
  - Unmapped: req_rdy is asserted internally in the first REQ cycle; no slave sees req_vld.
  - Masters must hold request fields stable while req_vld=1 and req_rdy=0. A master dropping req_vld in REQ is a protocol violation; behaviour is undefined.
- RSP:
  - m_rsp_vld_o[gnt] = s_rsp_vld_i[slv]; m_data_o[gnt] = s_data_i[slv]; s_rsp_rdy_o[slv] = m_rsp_rdy_i[gnt]. m_err_o = 0.
  - Unmapped: rsp_vld=1, data=32'h0, err=1.
  - On the rsp vld&rdy handshake: rr_ptr = (gnt+1) mod MASTER_NUM; go to IDLE.
  - Back-to-back transactions therefore take at least 3 cycles (IDLE, REQ, RSP).
- Non-granted masters always see req_rdy=0, rsp_vld=0, data=0, err=0.
- Slave-side rsp_vld outside RSP is ignored and not forwarded.
- All datapath outputs are AND-masked by the registered one-hot grant and slave select; no X propagation from unselected ports.
- Single master requesting continuously: it is granted every transaction. Fairness bound: any requester is served within MASTER_NUM transactions.

Optional Feature:
RIB_TIMEOUT_EN:
- Defined: a 16-bit counter clears on entry to REQ and on the REQ->RSP transition, and increments each REQ/RSP cycle.
  - Reaching TIMEOUT_CYCLES in REQ: assert m_req_rdy_o[gnt] for one cycle, then enter ERR.
  - Reaching TIMEOUT_CYCLES in RSP: enter ERR.
  - ERR: m_rsp_vld_o[gnt]=1, err=1, data=32'h0; all slave outputs 0. On rsp_rdy, update rr_ptr and go to IDLE.
  - A late slave response is dropped, because s_rsp_rdy_o stays 0.
- Undefined: no counter and no ERR state; the bus waits indefinitely. m_err_o is driven only by the decode error.

Decomposition:
- Package rib_pkg holds:
  - RIB_ADDR_W=32, RIB_DATA_W=32, RIB_SEL_W=4, RIB_DEC_BITS=4.
  - State enum (IDLE, REQ, RSP, ERR).
  - RIB_ERR_DATA=32'h0.
- Sub-module rib_rr_arbiter (param N): inputs req[N-1:0] and ptr; outputs one-hot gnt and index. Purely combinational; the pointer register lives in rib_rr_bus.

Test Plan:
- M=4, S=5. m1 reads 0x2000_0010 (s2 rdy immediate, rsp data 0xCAFE_F00D after 2 cycles) -> s2_addr_o=0x0000_0010, other s*_req_vld_o=0, m1 gets data, err=0, rr_ptr=2.
- m0..m3 all requesting continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each transaction ≥3 cycles.
- m2 writes 0x9000_0000 (unmapped) -> no s*_req_vld_o, m2 gets req_rdy, then rsp_vld=1, err=1, data=0.
- s0 holds req_rdy=0 for 5 cycles, m0 rsp_rdy=0 for 3 cycles -> req_vld and addr stable throughout, rsp_vld held, single handshake, no duplicate.
- rst_n pulled low during RSP with m3 granted -> all outputs 0 immediately; after release rr_ptr=0 and the m0 request is granted first.
- With RIB_TIMEOUT_EN, TIMEOUT_CYCLES=8, s1 never asserts rsp_vld -> after 8 RSP cycles m_rsp_vld_o=1, err=1, s1_rsp_rdy_o=0; return to IDLE.
